// File: rtl/tc_pkg.sv
// Shared sizing and FSM encoding for the D-buffer writeback path.
// The D buffer and its bench use the same package so geometry stays consistent.
package tc_pkg;

  localparam int M          = 16;   // rows drained per job
  localparam int N          = 16;   // elements per row
  localparam int DW_DATA    = 16;   // element width
  localparam int DW_COL     = 4;    // row index width
  localparam int DW_MEM     = 256;  // memory beat width (N*DW_DATA)
  localparam int FIFO_CNT_W = 2;    // occupancy width of the 2-entry skid FIFO

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } tc_state_e;

  // Debug view of the writeback engine for checkers and waveforms.
  typedef struct packed {
    tc_state_e             state;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  fifo_full;
    logic                  inflight;
  } tc_dbg_t;

endpackage

// File: rtl/tc_skid_fifo.sv
// Two-entry FIFO holding {address, row} beats between the D-buffer read and
// the memory writer. A push and a pop in the same cycle leave the count alone;
// a push while full is accepted only when the head leaves in that same cycle.
module tc_skid_fifo
  import tc_pkg::*;
#(
  parameter int W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [W-1:0]          din,
  output logic [W-1:0]          dout,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [W-1:0]          mem_q [2];
  logic [W-1:0]          mem_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  do_push, do_pop;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next storage, pointers and occupancy from this cycle's push/pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 2'd1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 2'd1;
    end
  end

  // Register the FIFO; reset empties it and zeroes the entries.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/tc_dwriteback.sv
// Drains M rows of the D buffer to a memory writer as one beat per row.
// Handshake: a beat transfers on a cycle where mem_valid and mem_ready are both
// high; once mem_valid rises, mem_valid/mem_addr/mem_data hold until transfer.
// Rows are read with a fixed 1-cycle latency; reads are throttled so that rows
// in the FIFO plus the read in flight never exceed the two FIFO entries.
module tc_dwriteback
  import tc_pkg::*;
#(
  parameter int M          = tc_pkg::M,
  parameter int N          = tc_pkg::N,
  parameter int DW_DATA    = tc_pkg::DW_DATA,
  parameter int DW_COL     = tc_pkg::DW_COL,
  parameter int DW_MEM     = tc_pkg::DW_MEM,
  parameter int ROW_STRIDE = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [31:0]            base_addr,
  output logic                   busy,
  output logic                   done,
  output logic [DW_COL-1:0]      row_out,
  input  logic [N*DW_DATA-1:0]   D_row_in,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output logic [31:0]            mem_addr,
  output logic [DW_MEM-1:0]      mem_data,
  output tc_dbg_t                dbg
);

  localparam logic [DW_COL-1:0] LAST_ROW = DW_COL'(M - 1);
  localparam int                FIFO_W   = 32 + DW_MEM;

  tc_state_e             state_q, state_d;
  logic [DW_COL-1:0]     row_q, row_d;
  logic [31:0]           base_q, base_d;
  logic                  inflight_q, inflight_d;
  logic [31:0]           inflight_addr_q, inflight_addr_d;

  logic                  fifo_full, fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [FIFO_W-1:0]     fifo_dout;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occupancy;
  logic [31:0]           row_addr;

  // Head of the FIFO is the beat on offer; a pop is a completed handshake.
  assign mem_valid = !fifo_empty;
  assign mem_addr  = fifo_dout[FIFO_W-1 -: 32];
  assign mem_data  = fifo_dout[DW_MEM-1:0];
  assign pop       = mem_valid && mem_ready;

  // A slot freed by this cycle's pop may be reused by this cycle's read, which
  // keeps one beat per cycle with ready held high.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign issue     = (state_q == RUN) && (occupancy < (pop ? 3'd3 : 3'd2));
  assign row_addr  = base_q + (32'(row_q) * 32'(ROW_STRIDE));

  assign busy    = (state_q == RUN) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
  assign row_out = row_q;

  assign dbg.state      = state_q;
  assign dbg.fifo_count = fifo_count;
  assign dbg.fifo_full  = fifo_full;
  assign dbg.inflight   = inflight_q;

  tc_skid_fifo #(
    .W (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q),
    .pop   (pop),
    .din   ({inflight_addr_q, D_row_in}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state, row sequencing and read tracking.
  always_comb begin
    state_d         = state_q;
    row_d           = row_q;
    base_d          = base_q;
    inflight_d      = issue;
    inflight_addr_d = inflight_addr_q;
    if (issue) begin
      inflight_addr_d = row_addr;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          base_d  = base_addr;
          row_d   = '0;
        end
      end
      RUN: begin
        // Row counter stops at the last row so it never wraps within a job.
        if (issue) begin
          if (row_q == LAST_ROW) begin
            state_d = DRAIN;
          end else begin
            row_d = row_q + DW_COL'(1);
          end
        end
      end
      DRAIN: begin
        // Leave as the final beat transfers so done follows it directly.
        if (!inflight_q && (fifo_empty || (fifo_count == 2'd1 && pop))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any job and any read in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      row_q           <= '0;
      base_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      base_q          <= base_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

endmodule

// File: doc/tc_dwriteback.md
TC_DWRITEBACK -- requirements
Module: tc_dwriteback

Interface
REQ-001 Parameter M, default 16: rows in the D buffer (rows drained per job).
REQ-002 Parameter N, default 16: elements per D row.
REQ-003 Parameter DW_DATA, default 16: element width in bits.
REQ-004 Parameter DW_COL, default 4: row-index width; M SHALL be at most 2**DW_COL.
REQ-005 Parameter DW_MEM, default 256: memory beat width; N*DW_DATA SHALL equal DW_MEM.
REQ-006 Parameter ROW_STRIDE, default 32: byte address increment per row.
REQ-007 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-008 Port reset, input, 1: synchronous, active-low reset.
REQ-009 Port start, input, 1: one-cycle job request; sampled only in IDLE.
REQ-010 Port base_addr, input, 32: byte address of row 0; captured with start.
REQ-011 Port busy, output, 1: high from the cycle after start acceptance until done.
REQ-012 Port done, output, 1: one-cycle pulse after the last beat is accepted.
REQ-013 Port row_out, output, DW_COL: row select to the D buffer read port.
REQ-014 Port D_row_in, input, N*DW_DATA: D buffer row data, valid one cycle after row_out.
REQ-015 Port mem_valid, output, 1: beat valid toward the memory writer.
REQ-016 Port mem_ready, input, 1: the memory writer accepts the beat when valid and ready are both high.
REQ-017 Port mem_addr, output, 32: byte address of the current beat.
REQ-018 Port mem_data, output, DW_MEM: one D row, with element j at bits [j*DW_DATA +: DW_DATA].

Function
REQ-019 FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE->RUN on start.
- RUN->DRAIN after row M-1 is issued.
- DRAIN->DONE when the FIFO is empty and no read is in flight.
- DONE->IDLE unconditionally.
REQ-020 In RUN, issue one row read per cycle only while (fifo_count + inflight) < 2; row_out increments 0..M-1 and never wraps within a job.
REQ-021 Capture D_row_in into the 2-entry FIFO in the cycle after the read issue (fixed read latency of 1).
REQ-022 mem_valid = FIFO non-empty; mem_data and mem_addr = FIFO head, with mem_addr = base_addr + row*ROW_STRIDE (32-bit wrap on overflow).
REQ-023 Once mem_valid is high, mem_valid, mem_addr and mem_data SHALL hold stable until the beat is accepted.
REQ-024 Pop the FIFO on mem_valid && mem_ready; a push and a pop in the same cycle SHALL keep the count unchanged.
REQ-025 Timing with mem_ready held high: start at edge 0 gives row_out=0 in cycle 1 and first mem_valid in cycle 3, then one beat per cycle, with done in the cycle after beat M-1.
REQ-026 start is ignored while busy; done and busy are never high together.
REQ-027 Beats leave strictly in row order 0..M-1; no beat is dropped or duplicated under any mem_ready pattern.

Reset
REQ-028 reset low at any edge, including mid-job: state=IDLE, FIFO emptied, in-flight read discarded.
REQ-029 Reset values of outputs: busy=0, done=0, mem_valid=0, row_out=0, mem_addr=0, mem_data=0.
REQ-030 The first start is accepted at the first edge with reset high.

Structure
REQ-031 Package tc_pkg SHALL hold M, N, DW_DATA, DW_COL, DW_MEM and the FSM state encoding, shared with the D buffer and its bench.
REQ-032 The 2-entry FIFO SHALL be a sub-module tc_skid_fifo with push/pop/full/empty/count, parameterised on width.
REQ-033 Target size is 120-400 lines of RTL, with no memories other than FIFO registers.

Verification
REQ-034 Buffer preloaded with D[i][j]=i*16+j, base_addr=0x1000, mem_ready=1, start -> 16 beats in cycles 3..18, addresses 0x1000..0x11E0, data matching, done in cycle 19.
REQ-035 mem_ready toggling 1,0,1,0 -> all 16 beats in order, with each held stable while ready is low and exactly 16 handshakes.
REQ-036 mem_ready low for 10 cycles after the first valid -> row_out stalls at most 2 rows ahead of the beat shown, with no overwrite, then resumes streaming.
REQ-037 start pulsed again at row 5 of a job -> ignored, with exactly one done and 16 beats.
REQ-038 reset low during beat 7 -> next cycle mem_valid=0, busy=0, row_out=0; a new start with base 0x2000 runs a clean 16-beat job from row 0.
REQ-039 start in the cycle after done with base_addr=0xFFFFFFF0 -> accepted, with the second beat's address wrapping to 0x00000010.
